// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - hazard, forwarding, flush and memory-wait control for a D/X/M RV32I pipeline
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid, id_opcode         D stage instruction presence and opcode
//   id_rs1, id_rs2, id_rd       D stage register indices
//   ex_redirect                 X resolved a taken branch / JAL / JALR
//   mem_busy                    data memory not ready, M cannot retire
//   stall_fd, bubble_x          hold PC/D, load NOP into X
//   flush_d, flush_x            kill D, kill instruction entering X
//   fwd_a, fwd_b                operand select: 0 regfile, 1 X result, 2 M data
//   stall_cnt                   saturating count of stall_fd cycles
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_fd,
  output logic              bubble_x,
  output logic              flush_d,
  output logic              flush_x,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] PEN_M1 = 3'(BR_PENALTY - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEM_WAIT} state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes;
    logic              is_load;
  } x_entry_t;

  // M only ever forwards writeback data, so its load flag is not kept.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes;
  } m_entry_t;

  state_t   state, state_nx;
  logic [2:0] cnt, cnt_nx;
  x_entry_t x_e;
  m_entry_t m_e;

  logic d_writes, d_load, d_use1, d_use2;
  logic x_hit_a, x_hit_b, m_hit_a, m_hit_b;
  logic raw_stall, flushing;

  always_comb begin
    d_writes = 1'b0;
    d_load   = 1'b0;
    d_use1   = 1'b0;
    d_use2   = 1'b0;
    case (id_opcode)
      OP_R:      begin d_writes = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1; end
      OP_I:      begin d_writes = 1'b1; d_use1 = 1'b1; end
      OP_LOAD:   begin d_writes = 1'b1; d_use1 = 1'b1; d_load = 1'b1; end
      OP_STORE:  begin d_use1 = 1'b1; d_use2 = 1'b1; end
      OP_BRANCH: begin d_use1 = 1'b1; d_use2 = 1'b1; end
      OP_JAL:    d_writes = 1'b1;
      OP_JALR:   begin d_writes = 1'b1; d_use1 = 1'b1; end
      OP_LUI:    d_writes = 1'b1;
      OP_AUIPC:  d_writes = 1'b1;
      default:   ;
    endcase
  end

  // x0 is hardwired, so a zero index never creates a dependency.
  assign x_hit_a = id_valid && d_use1 && (id_rs1 != '0) && x_e.valid && x_e.writes && (x_e.rd == id_rs1);
  assign x_hit_b = id_valid && d_use2 && (id_rs2 != '0) && x_e.valid && x_e.writes && (x_e.rd == id_rs2);
  assign m_hit_a = id_valid && d_use1 && (id_rs1 != '0) && m_e.valid && m_e.writes && (m_e.rd == id_rs1);
  assign m_hit_b = id_valid && d_use2 && (id_rs2 != '0) && m_e.valid && m_e.writes && (m_e.rd == id_rs2);

  always_comb begin
    if (FWD_EN != 0) raw_stall = (x_hit_a || x_hit_b) && x_e.is_load;
    else             raw_stall = x_hit_a || x_hit_b || m_hit_a || m_hit_b;
  end

  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (FWD_EN != 0 && rst_n) begin
      // A load in X has no result yet; fall through to M (a stall covers it).
      if (x_hit_a && !x_e.is_load) fwd_a = 2'd1;
      else if (m_hit_a)            fwd_a = 2'd2;
      if (x_hit_b && !x_e.is_load) fwd_b = 2'd1;
      else if (m_hit_b)            fwd_b = 2'd2;
    end
  end

  assign flushing = ex_redirect || (state == S_FLUSH);

  // mem_busy freezes everything; flush beats the RAW stall since the
  // stalled instruction is on the wrong path anyway.
  assign stall_fd = rst_n && (mem_busy || (!flushing && raw_stall));
  assign bubble_x = rst_n && !mem_busy && !flushing && raw_stall;
  assign flush_d  = rst_n && !mem_busy && flushing;
  assign flush_x  = flush_d;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (mem_busy) state_nx = S_MEM_WAIT;
        else if (ex_redirect) begin
          cnt_nx   = PEN_M1;
          state_nx = (PEN_M1 != 3'd0) ? S_FLUSH : S_RUN;
        end
      end
      S_FLUSH: begin
        if (mem_busy) state_nx = S_MEM_WAIT;
        else if (ex_redirect) begin
          cnt_nx   = PEN_M1;
          state_nx = (PEN_M1 != 3'd0) ? S_FLUSH : S_RUN;
        end else if (cnt <= 3'd1) begin
          cnt_nx   = 3'd0;
          state_nx = S_RUN;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_busy) begin
          if (ex_redirect) begin
            cnt_nx   = PEN_M1;
            state_nx = (PEN_M1 != 3'd0) ? S_FLUSH : S_RUN;
          end else begin
            state_nx = (cnt != 3'd0) ? S_FLUSH : S_RUN;
          end
        end
      end
      default: begin
        state_nx = S_RUN;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Tracking follows the pipe registers: it holds exactly when they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_e <= '0;
      m_e <= '0;
    end else if (!mem_busy) begin
      m_e <= '{valid: x_e.valid, rd: x_e.rd, writes: x_e.writes};
      if (id_valid && !bubble_x && !flush_x)
        x_e <= '{valid: 1'b1, rd: id_rd, writes: d_writes, is_load: d_load};
      else
        x_e <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_fd && (stall_cnt != '1))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, ex_redirect, mem_busy;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic stall_fd, bubble_x, flush_d, flush_x;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic nf_stall_fd, nf_bubble_x, nf_flush_d, nf_flush_x;
  logic [1:0] nf_fwd_a, nf_fwd_b;
  logic [3:0] nf_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1), .BR_PENALTY(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .stall_fd(stall_fd), .bubble_x(bubble_x), .flush_d(flush_d),
    .flush_x(flush_x), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(0), .BR_PENALTY(2), .CNT_W(4)) dut_nf (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .stall_fd(nf_stall_fd), .bubble_x(nf_bubble_x), .flush_d(nf_flush_d),
    .flush_x(nf_flush_x), .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .stall_cnt(nf_stall_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = r1;
    id_rs2    = r2;
    id_rd     = rd;
  endtask

  task automatic idle();
    set_d(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_busy = 1'b1;
    ex_redirect = 1'b1;
    set_d(1'b1, OP_R, 5'd3, 5'd4, 5'd5);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {stall_fd, bubble_x, flush_d, flush_x});
    end
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    n_cmp++;
    if ({nf_stall_fd, nf_flush_d, nf_stall_cnt} !== 6'd0) begin
      n_bad++; $display("FAIL reset_nf: got %b want 0", {nf_stall_fd, nf_flush_d, nf_stall_cnt});
    end
    next_cycle();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_release: got %b want 0000", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
  endtask

  task automatic test_fwd_x();
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_bad++; $display("FAIL fwd_empty: got %b want 0000", {fwd_a, fwd_b});
    end
    next_cycle();
    set_d(1'b1, OP_R, 5'd5, 5'd6, 5'd8);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b, stall_fd} !== {2'd1, 2'd0, 1'b0}) begin
      n_bad++; $display("FAIL fwd_x_rs1: got a=%0d b=%0d st=%b want a=1 b=0 st=0", fwd_a, fwd_b, stall_fd);
    end
    next_cycle();
    set_d(1'b1, OP_R, 5'd8, 5'd5, 5'd5);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'd1, 2'd2}) begin
      n_bad++; $display("FAIL fwd_x_and_m: got a=%0d b=%0d want a=1 b=2", fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
    next_cycle();
    set_d(1'b1, OP_I, 5'd5, 5'd5, 5'd1);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'd1, 2'd0}) begin
      n_bad++; $display("FAIL fwd_x_priority: got a=%0d b=%0d want a=1 b=0", fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_ST, 5'd1, 5'd5, 5'd0);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'd1, 2'd2}) begin
      n_bad++; $display("FAIL fwd_store: got a=%0d b=%0d want a=1 b=2", fwd_a, fwd_b);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1'b1, OP_LD, 5'd1, 5'd0, 5'd7);
    next_cycle();
    set_d(1'b1, OP_R, 5'd2, 5'd7, 5'd3);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x, fwd_b} !== {4'b1100, 2'd0}) begin
      n_bad++; $display("FAIL load_use_stall: got %b fwd_b=%0d want 1100 fwd_b=0", {stall_fd, bubble_x, flush_d, flush_x}, fwd_b);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, fwd_a, fwd_b} !== {2'b00, 2'd0, 2'd2}) begin
      n_bad++; $display("FAIL load_use_after: got st=%b bx=%b a=%0d b=%0d want 0 0 0 2", stall_fd, bubble_x, fwd_a, fwd_b);
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_bad++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    next_cycle();
    set_d(1'b1, OP_LD, 5'd1, 5'd0, 5'd9);
    next_cycle();
    set_d(1'b0, OP_R, 5'd9, 5'd9, 5'd12);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, fwd_a, fwd_b} !== 5'b0) begin
      n_bad++; $display("FAIL invalid_d: got st=%b a=%0d b=%0d want 0 0 0", stall_fd, fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_R, 5'd12, 5'd9, 5'd4);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, fwd_a, fwd_b} !== {1'b0, 2'd0, 2'd2}) begin
      n_bad++; $display("FAIL invalid_d_next: got st=%b a=%0d b=%0d want 0 0 2", stall_fd, fwd_a, fwd_b);
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_bad++; $display("FAIL invalid_d_cnt: got %0d want 1", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_x0_and_decode();
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd0);
    next_cycle();
    set_d(1'b1, OP_LD, 5'd0, 5'd0, 5'd9);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_bad++; $display("FAIL x0_nomatch: got a=%0d b=%0d want 0 0", fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_LUI, 5'd9, 5'd9, 5'd4);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, fwd_a, fwd_b} !== 6'b0) begin
      n_bad++; $display("FAIL lui_no_use: got st=%b a=%0d b=%0d want 0 0 0", stall_fd, fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_JAL, 5'd4, 5'd4, 5'd1);
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, fwd_a, fwd_b} !== 5'b0) begin
      n_bad++; $display("FAIL jal_no_use: got st=%b a=%0d b=%0d want 0 0 0", stall_fd, fwd_a, fwd_b);
    end
    next_cycle();
    set_d(1'b1, OP_JALR, 5'd1, 5'd4, 5'd2);
    @(negedge clk);
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'd1, 2'd0}) begin
      n_bad++; $display("FAIL jalr_fwd: got a=%0d b=%0d want 1 0", fwd_a, fwd_b);
    end
    next_cycle();
  endtask

  task automatic test_redirect();
    do_reset();
    set_d(1'b1, OP_LD, 5'd1, 5'd0, 5'd7);
    next_cycle();
    set_d(1'b1, OP_R, 5'd7, 5'd2, 5'd3);
    ex_redirect = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0011) begin
      n_bad++; $display("FAIL redirect_c0: got %b want 0011", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
    ex_redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0011) begin
      n_bad++; $display("FAIL redirect_c1: got %b want 0011", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0000) begin
      n_bad++; $display("FAIL redirect_c2: got %b want 0000", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ctrl [4];
    logic       redir [4];
    exp_ctrl[0] = 4'b0011; redir[0] = 1'b1;
    exp_ctrl[1] = 4'b0011; redir[1] = 1'b1;
    exp_ctrl[2] = 4'b0011; redir[2] = 1'b0;
    exp_ctrl[3] = 4'b0000; redir[3] = 1'b0;
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 4; i++) begin
      ex_redirect = redir[i];
      @(negedge clk);
      n_cmp++;
      if ({stall_fd, bubble_x, flush_d, flush_x} !== exp_ctrl[i]) begin
        n_bad++; $display("FAIL b2b_redirect_c%0d: got %b want %b", i, {stall_fd, bubble_x, flush_d, flush_x}, exp_ctrl[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_busy_flush();
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
    next_cycle();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd6);
    ex_redirect = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0011) begin
      n_bad++; $display("FAIL mb_redirect: got %b want 0011", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
    ex_redirect = 1'b0;
    mem_busy = 1'b1;
    set_d(1'b1, OP_R, 5'd5, 5'd6, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_fd, bubble_x, flush_d, flush_x, fwd_a, fwd_b} !== {4'b1000, 2'd2, 2'd0}) begin
        n_bad++; $display("FAIL mb_frozen_c%0d: got %b a=%0d b=%0d want 1000 a=2 b=0", i, {stall_fd, bubble_x, flush_d, flush_x}, fwd_a, fwd_b);
      end
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, fwd_a} !== {1'b0, 2'd2}) begin
      n_bad++; $display("FAIL mb_release: got st=%b a=%0d want st=0 a=2", stall_fd, fwd_a);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0011) begin
      n_bad++; $display("FAIL mb_flush_resume: got %b want 0011", {stall_fd, bubble_x, flush_d, flush_x});
    end
    n_cmp++;
    if (stall_cnt !== 16'd3) begin
      n_bad++; $display("FAIL mb_cnt: got %0d want 3", stall_cnt);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0000) begin
      n_bad++; $display("FAIL mb_flush_done: got %b want 0000", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
  endtask

  task automatic test_fwd_en0();
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    next_cycle();
    set_d(1'b1, OP_R, 5'd3, 5'd4, 5'd5);
    @(negedge clk);
    n_cmp++;
    if ({nf_stall_fd, nf_bubble_x, nf_fwd_a} !== {2'b11, 2'd0}) begin
      n_bad++; $display("FAIL nofwd_c0: got st=%b bx=%b a=%0d want 1 1 0", nf_stall_fd, nf_bubble_x, nf_fwd_a);
    end
    n_cmp++;
    if ({stall_fd, fwd_a} !== {1'b0, 2'd1}) begin
      n_bad++; $display("FAIL fwd_same_case: got st=%b a=%0d want 0 1", stall_fd, fwd_a);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({nf_stall_fd, nf_bubble_x, nf_fwd_a} !== {2'b11, 2'd0}) begin
      n_bad++; $display("FAIL nofwd_c1: got st=%b bx=%b a=%0d want 1 1 0", nf_stall_fd, nf_bubble_x, nf_fwd_a);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({nf_stall_fd, nf_bubble_x, nf_fwd_a} !== {2'b00, 2'd0}) begin
      n_bad++; $display("FAIL nofwd_c2: got st=%b bx=%b a=%0d want 0 0 0", nf_stall_fd, nf_bubble_x, nf_fwd_a);
    end
    n_cmp++;
    if (nf_stall_cnt !== 4'd2) begin
      n_bad++; $display("FAIL nofwd_cnt: got %0d want 2", nf_stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_stall_saturate();
    do_reset();
    mem_busy = 1'b1;
    repeat (20) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 16'd20) begin
      n_bad++; $display("FAIL cnt_20: got %0d want 20", stall_cnt);
    end
    n_cmp++;
    if (nf_stall_cnt !== 4'd15) begin
      n_bad++; $display("FAIL cnt_saturate: got %0d want 15", nf_stall_cnt);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_d(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    ex_redirect = 1'b1;
    next_cycle();
    ex_redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({flush_d, flush_x} !== 2'b11) begin
      n_bad++; $display("FAIL mid_flush_pre: got %b want 11", {flush_d, flush_x});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x, fwd_a, fwd_b} !== 8'd0) begin
      n_bad++; $display("FAIL mid_flush_async: got %b want 0", {stall_fd, bubble_x, flush_d, flush_x, fwd_a, fwd_b});
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall_fd, bubble_x, flush_d, flush_x} !== 4'b0000) begin
      n_bad++; $display("FAIL mid_flush_run: got %b want 0000", {stall_fd, bubble_x, flush_d, flush_x});
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_fwd_x();
    test_load_use();
    test_x0_and_decode();
    test_redirect();
    test_back_to_back();
    test_mem_busy_flush();
    test_fwd_en0();
    test_stall_saturate();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
